// File: rtl/control_pkg.sv
// Shared opcode/state encodings and field widths for the control sequencer.
package control_pkg;

    localparam int OPCODE_WIDTH  = 5;
    localparam int ALU_SEL_WIDTH = 4;
    localparam logic [ALU_SEL_WIDTH-1:0] ALU_SEL_MOVI = 4'b1010;

    // R-type is any opcode with the top bit clear; unlisted 1xxxx codes are NOPs
    typedef enum logic [OPCODE_WIDTH-1:0] {
        OP_LOAD  = 5'b10000,
        OP_STORE = 5'b10001,
        OP_MOVI  = 5'b10100,
        OP_JMP   = 5'b11000,
        OP_BZ    = 5'b11001,
        OP_BP    = 5'b11010,
        OP_HALT  = 5'b11111
    } opcode_e;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_WRITEBACK,
        ST_HALT
    } state_e;

endpackage

// File: rtl/control_sequencer_if.sv
// Program-memory handshake, ALU flags and datapath control bundle of the sequencer.
interface control_sequencer_if
    import control_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int REG_ADDR_WIDTH = 3,
    parameter int PC_WIDTH       = 8
);
    logic                      stall;
    logic                      pm_ack;
    logic [DATA_WIDTH-1:0]     PM_data;
    logic                      zero_flag;
    logic                      pos_flag;
    logic                      pm_req;
    logic [PC_WIDTH-1:0]       PC;
    logic [REG_ADDR_WIDTH-1:0] rs_addr;
    logic [REG_ADDR_WIDTH-1:0] rt_addr;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0]     imm_data;
    logic [ALU_SEL_WIDTH-1:0]  alu_sel;
    logic                      imm_sel;
    logic                      mem_sel;
    logic                      rf_write;
    logic                      mem_write;
    logic                      halted;

    modport master (
        input  stall, pm_ack, PM_data, zero_flag, pos_flag,
        output pm_req, PC, rs_addr, rt_addr, rd_addr, imm_data, alu_sel,
               imm_sel, mem_sel, rf_write, mem_write, halted
    );

    modport slave (
        output stall, pm_ack, PM_data, zero_flag, pos_flag,
        input  pm_req, PC, rs_addr, rt_addr, rd_addr, imm_data, alu_sel,
               imm_sel, mem_sel, rf_write, mem_write, halted
    );
endinterface

// File: rtl/instr_decode.sv
// Combinational instruction decoder: splits the latched instruction into
// register fields, immediates and per-class control bits.
module instr_decode
    import control_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int REG_ADDR_WIDTH = 3,
    parameter int PC_WIDTH       = 8
) (
    input  logic [DATA_WIDTH-1:0]     i_ir,
    output logic [REG_ADDR_WIDTH-1:0] o_rd,
    output logic [REG_ADDR_WIDTH-1:0] o_rs,
    output logic [REG_ADDR_WIDTH-1:0] o_rt,
    output logic [DATA_WIDTH-1:0]     o_imm,
    output logic [PC_WIDTH-1:0]       o_pc_ofs,
    output logic [ALU_SEL_WIDTH-1:0]  o_alu_sel,
    output logic                      o_imm_sel,
    output logic                      o_mem_sel,
    output logic                      o_wr_rf,
    output logic                      o_store,
    output logic                      o_jmp,
    output logic                      o_bz,
    output logic                      o_bp,
    output logic                      o_halt
);
    localparam int IMM_W = DATA_WIDTH - OPCODE_WIDTH - REG_ADDR_WIDTH;

    logic [OPCODE_WIDTH-1:0] w_op;
    logic [IMM_W-1:0]        w_imm;
    logic [DATA_WIDTH-1:0]   w_imm_sext;

    // rs/rt overlap the immediate; which one is meaningful depends on the opcode
    assign w_op  = i_ir[DATA_WIDTH-1 -: OPCODE_WIDTH];
    assign o_rd  = i_ir[DATA_WIDTH-OPCODE_WIDTH-1 -: REG_ADDR_WIDTH];
    assign o_rs  = i_ir[DATA_WIDTH-OPCODE_WIDTH-REG_ADDR_WIDTH-1 -: REG_ADDR_WIDTH];
    assign o_rt  = i_ir[DATA_WIDTH-OPCODE_WIDTH-2*REG_ADDR_WIDTH-1 -: REG_ADDR_WIDTH];
    assign w_imm = i_ir[IMM_W-1:0];

    assign o_imm      = {{(DATA_WIDTH-IMM_W){1'b0}}, w_imm};
    assign w_imm_sext = {{(DATA_WIDTH-IMM_W){w_imm[IMM_W-1]}}, w_imm};
    assign o_pc_ofs   = w_imm_sext[PC_WIDTH-1:0];

    always_comb begin
        o_alu_sel = '0;
        o_imm_sel = 1'b0;
        o_mem_sel = 1'b0;
        o_wr_rf   = 1'b0;
        o_store   = 1'b0;
        o_jmp     = 1'b0;
        o_bz      = 1'b0;
        o_bp      = 1'b0;
        o_halt    = 1'b0;
        if (!w_op[OPCODE_WIDTH-1]) begin
            o_alu_sel = w_op[ALU_SEL_WIDTH-1:0];
            o_wr_rf   = 1'b1;
        end else begin
            case (w_op)
                OP_MOVI: begin
                    o_alu_sel = ALU_SEL_MOVI;
                    o_imm_sel = 1'b1;
                    o_wr_rf   = 1'b1;
                end
                OP_LOAD: begin
                    o_mem_sel = 1'b1;
                    o_wr_rf   = 1'b1;
                end
                OP_STORE: o_store = 1'b1;
                OP_JMP:   o_jmp   = 1'b1;
                OP_BZ:    o_bz    = 1'b1;
                OP_BP:    o_bp    = 1'b1;
                OP_HALT:  o_halt  = 1'b1;
                default:  ;
            endcase
        end
    end
endmodule

// File: rtl/control_sequencer.sv
// Four-phase instruction sequencer: fetch/decode/execute/writeback FSM with
// PC and IR registers, stall freeze and a terminal HALT state.
//
// state        | meaning
// ST_FETCH     | pm_req high, wait for pm_ack, latch IR
// ST_DECODE    | fields valid from IR; HALT opcode branches to ST_HALT
// ST_EXECUTE   | STORE strobe, branch flags sampled
// ST_WRITEBACK | register-file strobe, PC advanced on exit
// ST_HALT      | terminal until reset
module control_sequencer
    import control_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int REG_ADDR_WIDTH = 3,
    parameter int PC_WIDTH       = 8
) (
    input  logic                clock,
    input  logic                reset,
    control_sequencer_if.master bus
);
    state_e                    r_state, w_state_next;
    logic [PC_WIDTH-1:0]       r_pc, w_pc_next, w_pc_ofs;
    logic [DATA_WIDTH-1:0]     r_ir, w_ir_dec, w_imm;
    logic                      r_taken;
    logic                      w_ir_load, w_pc_update, w_flags_sample;
    logic                      w_pm_req, w_rf_write, w_mem_write;
    logic [REG_ADDR_WIDTH-1:0] w_rd, w_rs, w_rt;
    logic [ALU_SEL_WIDTH-1:0]  w_alu_sel;
    logic                      w_imm_sel, w_mem_sel, w_wr_rf, w_store;
    logic                      w_jmp, w_bz, w_bp, w_halt;

    // Decoding a zero word while reset is high forces every field output to 0
    assign w_ir_dec = reset ? '0 : r_ir;

    instr_decode #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
        .PC_WIDTH       (PC_WIDTH)
    ) u_decode (
        .i_ir      (w_ir_dec),
        .o_rd      (w_rd),
        .o_rs      (w_rs),
        .o_rt      (w_rt),
        .o_imm     (w_imm),
        .o_pc_ofs  (w_pc_ofs),
        .o_alu_sel (w_alu_sel),
        .o_imm_sel (w_imm_sel),
        .o_mem_sel (w_mem_sel),
        .o_wr_rf   (w_wr_rf),
        .o_store   (w_store),
        .o_jmp     (w_jmp),
        .o_bz      (w_bz),
        .o_bp      (w_bp),
        .o_halt    (w_halt)
    );

    assign w_pc_next = r_taken ? (r_pc + PC_WIDTH'(1) + w_pc_ofs) : (r_pc + PC_WIDTH'(1));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_FETCH;
            r_pc    <= '0;
            r_ir    <= '0;
            r_taken <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_ir_load)
                r_ir <= bus.PM_data;
            if (w_flags_sample)
                r_taken <= w_jmp | (w_bz & bus.zero_flag) | (w_bp & bus.pos_flag);
            if (w_pc_update)
                r_pc <= w_pc_next;
        end
    end

    // A stalled cycle advances nothing and emits no strobe; the strobe
    // reappears once stall drops because the state was held.
    always_comb begin
        w_state_next   = r_state;
        w_ir_load      = 1'b0;
        w_pc_update    = 1'b0;
        w_flags_sample = 1'b0;
        w_pm_req       = 1'b0;
        w_rf_write     = 1'b0;
        w_mem_write    = 1'b0;
        if (!bus.stall) begin
            case (r_state)
                ST_FETCH: begin
                    w_pm_req = 1'b1;
                    if (bus.pm_ack) begin
                        w_ir_load    = 1'b1;
                        w_state_next = ST_DECODE;
                    end
                end
                ST_DECODE:
                    w_state_next = w_halt ? ST_HALT : ST_EXECUTE;
                ST_EXECUTE: begin
                    w_mem_write    = w_store;
                    w_flags_sample = 1'b1;
                    w_state_next   = ST_WRITEBACK;
                end
                ST_WRITEBACK: begin
                    w_rf_write   = w_wr_rf;
                    w_pc_update  = 1'b1;
                    w_state_next = ST_FETCH;
                end
                default: ;
            endcase
        end
    end

    assign bus.pm_req    = w_pm_req & ~reset;
    assign bus.rf_write  = w_rf_write & ~reset;
    assign bus.mem_write = w_mem_write & ~reset;
    assign bus.halted    = (r_state == ST_HALT) & ~reset;
    assign bus.PC        = reset ? '0 : r_pc;
    assign bus.rd_addr   = w_rd;
    assign bus.rs_addr   = w_rs;
    assign bus.rt_addr   = w_rt;
    assign bus.imm_data  = w_imm;
    assign bus.alu_sel   = w_alu_sel;
    assign bus.imm_sel   = w_imm_sel;
    assign bus.mem_sel   = w_mem_sel;
endmodule
